// File: rtl/clock_pkg.sv
// Shared encodings and limits for the clock setting controller.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_SEC  = 2'd3
    } state_t;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    localparam logic [5:0] HOUR_MAX   = 6'd23;
    localparam logic [5:0] MINSEC_MAX = 6'd59;

    // One wrapping step up or down within 0..max.
    function automatic logic [5:0] step_wrap(input logic [5:0] value,
                                             input logic [5:0] max,
                                             input logic       up);
        if (up)
            return (value >= max) ? 6'd0 : value + 6'd1;
        else
            return (value == 6'd0) ? max : value - 6'd1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, counting debouncer and one-cycle press pulse for one button.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            level <= 1'b0;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                // press rises together with the level
                level <= sync[1];
                press <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/clock_setter.sv
// Three-button time editor: mode walks hour/min/sec fields, inc/dec edit, load on exit.
// Optional auto-repeat while inc/dec is held: define CLOCK_SETTER_AUTOREPEAT_EN.
//   state       | meaning
//   ST_IDLE     | not editing, set_* held
//   ST_SET_HOUR | editing hours
//   ST_SET_MIN  | editing minutes
//   ST_SET_SEC  | editing seconds; next mode press loads
module clock_setter
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TIMEOUT_CYCLES  = 50000000,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    input  logic [5:0] cur_seconds,
    output logic [4:0] set_hours,
    output logic [5:0] set_minutes,
    output logic [5:0] set_seconds,
    output logic       load,
    output logic       setting,
    output logic [1:0] field_sel
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t     state;
    logic       mode_level, inc_level, dec_level;
    logic       mode_press, inc_press, dec_press, press_any;
    logic       rep_up, rep_dn, edit_en, edit_up;
    logic [5:0] hour_step, min_step, sec_step;
    logic       unused_levels;

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk(clk), .reset(reset), .btn(btn_mode), .level(mode_level), .press(mode_press));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk(clk), .reset(reset), .btn(btn_inc), .level(inc_level), .press(inc_press));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
        .clk(clk), .reset(reset), .btn(btn_dec), .level(dec_level), .press(dec_press));

    assign press_any = mode_press | inc_press | dec_press;
    assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset)
            tmo_cnt <= '0;
        else if (state == ST_IDLE || press_any || tmo_hit)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

`ifdef CLOCK_SETTER_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_hit, excl_up, excl_dn;

    assign excl_up = inc_level & ~dec_level;
    assign excl_dn = dec_level & ~inc_level;
    assign rep_hit = (rep_cnt == REP_W'(REPEAT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset)
            rep_cnt <= '0;
        else if (state == ST_IDLE || press_any || !(excl_up || excl_dn) || rep_hit)
            rep_cnt <= '0;
        else
            rep_cnt <= rep_cnt + REP_W'(1);
    end

    assign rep_up        = (state != ST_IDLE) & excl_up & rep_hit;
    assign rep_dn        = (state != ST_IDLE) & excl_dn & rep_hit;
    assign unused_levels = mode_level;
`else
    assign rep_up        = 1'b0;
    assign rep_dn        = 1'b0;
    assign unused_levels = ^{mode_level, inc_level, dec_level};
`endif

    // Real presses take precedence; repeats only fire on press-free cycles.
    assign edit_en = (inc_press ^ dec_press) | (~press_any & (rep_up | rep_dn));
    assign edit_up = press_any ? inc_press : rep_up;

    always_comb begin
        hour_step = step_wrap({1'b0, set_hours}, HOUR_MAX, edit_up);
        min_step  = step_wrap(set_minutes, MINSEC_MAX, edit_up);
        sec_step  = step_wrap(set_seconds, MINSEC_MAX, edit_up);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            set_hours   <= '0;
            set_minutes <= '0;
            set_seconds <= '0;
            load        <= 1'b0;
            setting     <= 1'b0;
            field_sel   <= FIELD_NONE;
        end else begin
            load <= 1'b0;
            if (state == ST_IDLE) begin
                if (mode_press) begin
                    set_hours   <= cur_hours;
                    set_minutes <= cur_minutes;
                    set_seconds <= cur_seconds;
                    state       <= ST_SET_HOUR;
                    setting     <= 1'b1;
                    field_sel   <= FIELD_HOUR;
                end
            end else if (mode_press) begin
                case (state)
                    ST_SET_HOUR: begin
                        state     <= ST_SET_MIN;
                        field_sel <= FIELD_MIN;
                    end
                    ST_SET_MIN: begin
                        state     <= ST_SET_SEC;
                        field_sel <= FIELD_SEC;
                    end
                    default: begin
                        state     <= ST_IDLE;
                        setting   <= 1'b0;
                        field_sel <= FIELD_NONE;
                        load      <= 1'b1;
                    end
                endcase
            end else if (tmo_hit && !press_any) begin
                state     <= ST_IDLE;
                setting   <= 1'b0;
                field_sel <= FIELD_NONE;
            end else if (edit_en) begin
                case (state)
                    ST_SET_HOUR: set_hours   <= hour_step[4:0];
                    ST_SET_MIN:  set_minutes <= min_step;
                    default:     set_seconds <= sec_step;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_setter.sv
// Directed bench for clock_setter with a cycle-level reference model and literal anchors.
module tb_clock_setter;
    localparam int D = 4;
    localparam int T = 200;
    localparam int R = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic [4:0] cur_hours = '0;
    logic [5:0] cur_minutes = '0, cur_seconds = '0;
    logic [4:0] set_hours;
    logic [5:0] set_minutes, set_seconds;
    logic       load, setting;
    logic [1:0] field_sel;

    int passed = 0;
    int total = 0;
    int load_cnt = 0;
    bit cmp_en = 1'b0;

    clock_setter #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T), .REPEAT_CYCLES(R)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
        .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds),
        .load(load), .setting(setting), .field_sel(field_sel));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: raw sample history, field values as integers, state as field index.
    int cyc = 0, m_st = 0, m_h = 0, m_m = 0, m_s = 0, last_press = 0, rep_start = 0;
    bit m_load = 1'b0;
    bit m_lvl[3];
    bit m_pulse[3];
    bit hist[3][D+2];
    bit raw[3];
    bit any_p, ex_up, ex_dn, f_up, f_dn, all_diff;

    task automatic step_field(input int dir);
        case (m_st)
            1: m_h = (m_h + 24 + dir) % 24;
            2: m_m = (m_m + 60 + dir) % 60;
            3: m_s = (m_s + 60 + dir) % 60;
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        cyc++;
        raw[0] = btn_mode; raw[1] = btn_inc; raw[2] = btn_dec;
        if (reset) begin
            m_st = 0; m_h = 0; m_m = 0; m_s = 0; m_load = 1'b0;
            last_press = cyc; rep_start = cyc;
            for (int b = 0; b < 3; b++) begin
                m_lvl[b] = 1'b0; m_pulse[b] = 1'b0;
                for (int k = 0; k < D + 2; k++) hist[b][k] = 1'b0;
            end
        end else begin
            any_p = m_pulse[0] | m_pulse[1] | m_pulse[2];
            ex_up = m_lvl[1] && !m_lvl[2];
            ex_dn = m_lvl[2] && !m_lvl[1];
            f_up = 1'b0; f_dn = 1'b0;
            if (any_p || m_st == 0 || !(ex_up || ex_dn)) rep_start = cyc;
            else if (cyc - rep_start == R) begin
`ifdef CLOCK_SETTER_AUTOREPEAT_EN
                f_up = ex_up; f_dn = ex_dn;
`endif
                rep_start = cyc;
            end
            m_load = 1'b0;
            if (m_st == 0) begin
                if (m_pulse[0]) begin
                    m_h = cur_hours; m_m = cur_minutes; m_s = cur_seconds; m_st = 1;
                end
            end else if (m_pulse[0]) begin
                if (m_st == 3) begin m_st = 0; m_load = 1'b1; end
                else m_st++;
            end else if (any_p) begin
                if (m_pulse[1] && !m_pulse[2]) step_field(1);
                else if (m_pulse[2] && !m_pulse[1]) step_field(-1);
            end else if (cyc - last_press == T) m_st = 0;
            else if (f_up) step_field(1);
            else if (f_dn) step_field(-1);
            if (any_p) last_press = cyc;
            // level flips once the last D synchronized samples all disagree with it
            for (int b = 0; b < 3; b++) begin
                for (int k = D + 1; k > 0; k--) hist[b][k] = hist[b][k-1];
                hist[b][0] = raw[b];
                m_pulse[b] = 1'b0;
                all_diff = 1'b1;
                for (int k = 2; k < D + 2; k++) if (hist[b][k] == m_lvl[b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_lvl[b] = hist[b][2];
                    m_pulse[b] = hist[b][2];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("set_hours", set_hours, m_h);
            check("set_minutes", set_minutes, m_m);
            check("set_seconds", set_seconds, m_s);
            check("load", load, int'(m_load));
            check("setting", setting, int'(m_st != 0));
            check("field_sel", field_sel, m_st);
            if (load) load_cnt++;
        end
    end

    task automatic push(input bit m, input bit i, input bit d, input int hold);
        btn_mode = m; btn_inc = i; btn_dec = d;
        repeat (hold) @(negedge clk);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        cur_hours = 5'(h); cur_minutes = 6'(m); cur_seconds = 6'(s);
    endtask

    task automatic expect_time(input string name, input int h, input int m, input int s);
        check({name, "_h"}, set_hours, h);
        check({name, "_m"}, set_minutes, m);
        check({name, "_s"}, set_seconds, s);
    endtask

    initial begin
        @(negedge clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        expect_time("reset", 0, 0, 0);
        check("reset_setting", setting, 0);
        check("reset_field", field_sel, 0);
        check("reset_load", load, 0);

        push(0, 1, 0, 8);
        expect_time("idle_inc_ignored", 0, 0, 0);

        set_cur(13, 45, 30);
        btn_mode = 1'b1; repeat (2) @(negedge clk);
        btn_mode = 1'b0; @(negedge clk);
        btn_mode = 1'b1; repeat (3) @(negedge clk);
        btn_mode = 1'b0; repeat (10) @(negedge clk);
        check("bounce_setting", setting, 0);

        push(1, 0, 0, 8);
        check("enter_setting", setting, 1);
        check("enter_field", field_sel, 1);
        expect_time("enter", 13, 45, 30);
        push(0, 1, 0, 8);
        push(1, 0, 0, 8);
        push(0, 1, 0, 8);
        push(1, 0, 0, 8);
        push(0, 1, 0, 8);
        check("sec_field", field_sel, 3);
        push(1, 0, 0, 8);
        expect_time("loaded", 14, 46, 31);
        check("loaded_field", field_sel, 0);
        check("load_pulses", load_cnt, 1);

        set_cur(23, 0, 58);
        push(1, 0, 0, 8);
        expect_time("enter2", 23, 0, 58);
        push(0, 1, 0, 8);
        check("hour_wrap_up", set_hours, 0);
        push(0, 0, 1, 8);
        check("hour_wrap_dn", set_hours, 23);
        push(1, 0, 0, 8);
        push(0, 0, 1, 8);
        check("min_wrap_dn", set_minutes, 59);
        push(0, 1, 1, 8);
        check("inc_dec_together", set_minutes, 59);
        push(1, 1, 0, 8);
        check("mode_inc_field", field_sel, 3);
        check("mode_inc_min", set_minutes, 59);
        check("mode_inc_sec", set_seconds, 58);
        push(0, 1, 0, 65);
`ifdef CLOCK_SETTER_AUTOREPEAT_EN
        check("held_inc_sec", set_seconds, 2);
`else
        check("held_inc_sec", set_seconds, 59);
`endif
        push(1, 0, 0, 8);
        check("load_pulses2", load_cnt, 2);

        set_cur(1, 2, 3);
        push(1, 0, 0, 8);
        push(1, 0, 0, 8);
        check("tmo_field", field_sel, 2);
        repeat (150) @(negedge clk);
        check("tmo_not_yet", setting, 1);
        repeat (60) @(negedge clk);
        check("tmo_setting", setting, 0);
        check("tmo_field_none", field_sel, 0);
        check("tmo_no_load", load_cnt, 2);

        set_cur(7, 8, 9);
        push(1, 0, 0, 8);
        push(1, 0, 0, 8);
        push(1, 0, 0, 8);
        check("rst_pre_field", field_sel, 3);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        expect_time("mid_reset", 0, 0, 0);
        check("mid_reset_setting", setting, 0);
        check("mid_reset_field", field_sel, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_reset_load", load_cnt, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/clock_setter.md
CLOCK_SETTER -- requirements
Module: clock_setter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive cycles a synchronized button must differ from its debounced level before that level flips.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000000, idle cycles in a set state before abort.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 12500000, auto-repeat step interval.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port btn_mode  input  1  raw asynchronous mode button, high = pressed.
REQ-007 SHALL have port btn_inc  input  1  raw asynchronous increment button.
REQ-008 SHALL have port btn_dec  input  1  raw asynchronous decrement button.
REQ-009 SHALL have port cur_hours / cur_minutes / cur_seconds  input  5/6/6  running time from counters.
REQ-010 SHALL have port set_hours / set_minutes / set_seconds  output  5/6/6  edited time values.
REQ-011 SHALL have port load  output  1  one-cycle strobe: counters take set_* values.
REQ-012 SHALL have port setting  output  1  high whenever not IDLE; display uses it to blank or blink.
REQ-013 SHALL have port field_sel  output  2  field under edit: 0 none, 1 hour, 2 minute, 3 second.

Function
REQ-014 SHALL pass each button through a 2-flop synchronizer, then the debouncer; the debounce counter clears on any cycle the synchronized input equals the debounced level.
REQ-015 SHALL emit a one-cycle press pulse on each debounced 0->1 transition, the same cycle the level rises.
REQ-016 SHALL implement FSM states IDLE, SET_HOUR, SET_MIN, SET_SEC.
REQ-017 SHALL, on a mode pulse in IDLE, copy cur_* into set_* and enter SET_HOUR.
REQ-018 SHALL advance on a mode pulse from SET_HOUR to SET_MIN and from SET_MIN to SET_SEC.
REQ-019 SHALL, on a mode pulse in SET_SEC, return to IDLE and assert load for exactly that transition cycle, with set_* holding the edited values.
REQ-020 SHALL, on an inc pulse, step the selected field by +1: hours wrap 23->0, minutes and seconds wrap 59->0.
REQ-021 SHALL, on a dec pulse, step the selected field by -1: hours wrap 0->23, minutes and seconds wrap 0->59.
REQ-022 SHALL ignore inc and dec in IDLE.
REQ-023 SHALL leave fields unchanged when inc and dec pulse in the same cycle.
REQ-024 SHALL, when mode pulses together with inc or dec, perform the mode transition and discard the inc or dec.
REQ-025 SHALL write the field edit on the cycle after the pulse.
REQ-026 SHALL restart the timeout counter on any press pulse, and return to IDLE without load after TIMEOUT_CYCLES cycles with no press.
REQ-027 SHALL hold set_* stable outside edits; load SHALL never assert other than per REQ-019.

Reset
REQ-028 SHALL, on reset: FSM=IDLE, set_*=0, load=0, setting=0, field_sel=0; synchronizers, debounced levels and all counters 0.
REQ-029 SHALL, when reset is asserted mid-edit, abort without asserting load.

Configuration
REQ-030 SHALL, with macro CLOCK_SETTER_AUTOREPEAT_EN defined: while inc (or dec) stays debounced-high in a set state, generate one additional step every REPEAT_CYCLES cycles after the initial press.
REQ-031 SHALL, without that macro, produce exactly one step per press, with no repeat counter synthesized.

Structure
REQ-032 SHALL take the FSM state enum, field_sel encodings, HOUR_MAX=23 and MINSEC_MAX=59 from shared package clock_pkg.
REQ-033 SHALL instantiate sub-module button_debouncer (synchronizer, debouncer, press pulse) once per button.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=200, REPEAT_CYCLES=20)
REQ-034 SHALL cover: cur=13:45:30, mode press -> setting=1, field_sel=1, set_*=13:45:30; bounce shorter than 4 cycles -> no pulse.
REQ-035 SHALL cover: in SET_HOUR at 23, inc -> 0; dec -> 23; in SET_MIN at 0, dec -> 59.
REQ-036 SHALL cover: from IDLE, mode x4 with edits 14:46:31 -> load high exactly 1 cycle, set_*=14:46:31, field_sel=0.
REQ-037 SHALL cover: inc and dec pressed together -> no field change; mode and inc together -> field advances, value unchanged.
REQ-038 SHALL cover: enter SET_MIN, no press for 200 cycles -> IDLE, load never asserted; reset during SET_SEC -> all outputs 0.
REQ-039 SHALL cover, with CLOCK_SETTER_AUTOREPEAT_EN: inc held 65 cycles after the pulse in SET_SEC from 58 -> 58->59->0->1->2 (1 press plus 3 repeats); without the macro -> 59 only.
